// File: rtl/codificador_display_pkg.sv
// Shared seven-segment definitions: segment bit indices, the active-low
// hex pattern table and the FSM state encoding used by the display blocks.
package codificador_display_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    // Active-low patterns, index = hex value, leftmost literal bit = segment a.
    localparam logic [0:6] SEG_PATTERNS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [0:6] hex_to_seg(input logic [3:0] value);
        return SEG_PATTERNS[value];
    endfunction

endpackage

// File: rtl/codificador_display_seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern into its
// hex nibble; valid is low for any pattern outside the 16-entry table.
module seg7_to_hex
    import codificador_display_pkg::*;
(
    input  logic [0:6] seg_in,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = 4'h0;
        valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_in == SEG_PATTERNS[i]) begin
                nibble = 4'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/codificador_display.sv
// Assembles a stream of seven-segment patterns into a DIGITS-nibble hex word
// with valid/ready handshakes on both sides and a sticky error flag.
module codificador_display
    import codificador_display_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [0:6]            seg_in,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    output logic [4*DIGITS-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  err_flag,
    input  logic                  err_clear
);

    localparam int WW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [3:0]    nibble;
    logic          digit_ok;

    seg7_to_hex u_lookup (
        .seg_in (seg_in),
        .nibble (nibble),
        .valid  (digit_ok)
    );

    // Handshake outputs are registered alongside the state so neither side
    // of the block sees a combinational path from its inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_COLLECT;
            word_out   <= '0;
            count      <= '0;
            err_flag   <= 1'b0;
            seg_ready  <= 1'b1;
            word_valid <= 1'b0;
        end else begin
            if (err_clear)
                err_flag <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (seg_valid && seg_ready) begin
                        if (digit_ok) begin
                            word_out <= (word_out << 4) | WW'(nibble);
                            count    <= count + CW'(1);
                            if (count == CW'(DIGITS - 1)) begin
                                state      <= ST_HOLD;
                                seg_ready  <= 1'b0;
                                word_valid <= 1'b1;
                            end
                        end else begin
                            // A bad pattern is dropped; setting beats a same-edge clear.
                            err_flag <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (word_ready) begin
                        state      <= ST_COLLECT;
                        word_out   <= '0;
                        count      <= '0;
                        seg_ready  <= 1'b1;
                        word_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_COLLECT;
                    seg_ready  <= 1'b1;
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codificador_display.sv
// Randomised and directed bench for codificador_display, checked every cycle
// against a queue-based model of the collected digits.
module tb_codificador_display;

    localparam int DIGITS = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [0:6]          seg_in;
    logic                seg_valid;
    logic                seg_ready;
    logic [4*DIGITS-1:0] word_out;
    logic                word_valid;
    logic                word_ready;
    logic                err_flag;
    logic                err_clear;

    int vec_count  = 0;
    int fail_count = 0;

    logic [0:6] ref_table [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int digits_q[$];
    bit m_hold;
    bit m_err;

    codificador_display #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err_flag   (err_flag),
        .err_clear  (err_clear)
    );

    always #5 clock = ~clock;

    function automatic int lookup(input logic [0:6] p);
        for (int i = 0; i < 16; i++)
            if (p == ref_table[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_word();
        logic [31:0] w = 0;
        foreach (digits_q[i]) w = w * 16 + digits_q[i];
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".seg_ready"}, 32'(seg_ready), 32'(!m_hold));
        check_output({tag, ".word_valid"}, 32'(word_valid), 32'(m_hold));
        check_output({tag, ".word_out"}, 32'(word_out), model_word());
        check_output({tag, ".err_flag"}, 32'(err_flag), 32'(m_err));
    endtask

    task automatic model_step(input logic [0:6] seg, input bit sv, input bit wr, input bit ec);
        bit err_set = 0;
        int idx;
        if (!m_hold) begin
            if (sv) begin
                idx = lookup(seg);
                if (idx >= 0) begin
                    digits_q.push_back(idx);
                    if (digits_q.size() == DIGITS) m_hold = 1;
                end else begin
                    err_set = 1;
                end
            end
        end else if (wr) begin
            m_hold = 0;
            digits_q.delete();
        end
        if (err_set) m_err = 1;
        else if (ec) m_err = 0;
    endtask

    task automatic apply_stimulus(input logic [0:6] seg, input bit sv, input bit wr, input bit ec);
        seg_in     = seg;
        seg_valid  = sv;
        word_ready = wr;
        err_clear  = ec;
        @(posedge clock);
        model_step(seg, sv, wr, ec);
        #1;
        check_all("cycle");
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        seg_valid  = 1'b0;
        word_ready = 1'b0;
        err_clear  = 1'b0;
        #1;
        digits_q.delete();
        m_hold = 0;
        m_err  = 0;
        check_all("async_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_all("reset_release");
    endtask

    initial begin
        int accepted;
        logic [0:6] pat;
        seg_in = '0;
        do_reset();

        // Word 0x1234
        apply_stimulus(7'b1001111, 1, 0, 0);
        apply_stimulus(7'b0010010, 1, 0, 0);
        apply_stimulus(7'b0000110, 1, 0, 0);
        apply_stimulus(7'b1001100, 1, 0, 0);
        check_output("word_1234", 32'(word_out), 32'h1234);
        check_output("hold_ready_low", 32'(seg_ready), 32'd0);

        // HOLD ignores incoming patterns until the word is taken
        for (int i = 0; i < 5; i++) apply_stimulus(7'b0000000, 1, 0, 0);
        check_output("hold_stable", 32'(word_out), 32'h1234);
        apply_stimulus(7'b0000000, 1, 1, 0);
        check_output("release_valid", 32'(word_valid), 32'd0);
        check_output("release_ready", 32'(seg_ready), 32'd1);

        // Invalid pattern inside a stream
        apply_stimulus(7'b0001000, 1, 0, 0);
        apply_stimulus(7'b1111111, 1, 0, 0);
        check_output("err_after_bad", 32'(err_flag), 32'd1);
        apply_stimulus(7'b1100000, 1, 0, 0);
        apply_stimulus(7'b0110001, 1, 0, 0);
        apply_stimulus(7'b1000010, 1, 0, 0);
        check_output("word_abcd", 32'(word_out), 32'hABCD);
        apply_stimulus(7'b0000000, 0, 1, 0);

        // Error set wins over same-edge clear
        apply_stimulus(7'b1111110, 1, 0, 1);
        check_output("err_set_wins", 32'(err_flag), 32'd1);
        apply_stimulus(7'b0000000, 0, 0, 1);
        check_output("err_cleared", 32'(err_flag), 32'd0);

        // Reset mid-word discards partial digits
        apply_stimulus(7'b1001111, 1, 0, 0);
        apply_stimulus(7'b0010010, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(7'b0111000, 1, 0, 0);
        check_output("word_ffff", 32'(word_out), 32'hFFFF);
        apply_stimulus(7'b0000000, 0, 1, 0);

        // Every 7-bit code as a single transfer from a clean state
        accepted = 0;
        for (int c = 0; c < 128; c++) begin
            do_reset();
            apply_stimulus(7'(c), 1, 0, 0);
            if (!err_flag) accepted++;
        end
        check_output("sweep_accepted", 32'(accepted), 32'd16);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) < 6) pat = ref_table[$urandom_range(0, 15)];
                else pat = 7'($urandom);
                apply_stimulus(pat, 1'($urandom_range(0, 1)),
                               $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule

// File: doc/codificador_display.md
CODIFICADOR_DISPLAY -- requirements
Module: codificador_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of hex digits per assembled word (legal range 1..8).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port seg_in  input  [0:6]  active-low segment pattern, bit 0 = segment a ... bit 6 = segment g.
REQ-005 SHALL have port seg_valid  input  1  seg_in holds a pattern to transfer.
REQ-006 SHALL have port seg_ready  output  1  block can accept a pattern this cycle.
REQ-007 SHALL have port word_out  output  [4*DIGITS-1:0]  assembled hex word, first digit received in the most significant nibble.
REQ-008 SHALL have port word_valid  output  1  word_out complete and stable.
REQ-009 SHALL have port word_ready  input  1  consumer takes word_out this cycle.
REQ-010 SHALL have port err_flag  output  1  sticky flag, at least one unrecognised pattern seen.
REQ-011 SHALL have port err_clear  input  1  synchronous clear of err_flag.

Function
REQ-012 SHALL map the 16 active-low patterns (a..g) 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0001100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000 to nibbles 0x0..0xF.
REQ-013 SHALL treat every other 7-bit pattern (112 codes) as invalid.
REQ-014 SHALL implement a two-state FSM: COLLECT (seg_ready=1, word_valid=0) and HOLD (seg_ready=0, word_valid=1).
REQ-015 SHALL drive seg_ready and word_valid from registered state only, with no combinational path from any input.
REQ-016 SHALL count a transfer when seg_valid=1 and seg_ready=1 on a rising clock edge.
REQ-017 SHALL, on a valid-pattern transfer, shift the accumulator left 4 bits, insert the nibble at bits [3:0], and increment the digit count.
REQ-018 SHALL, on an invalid-pattern transfer, set err_flag and leave the accumulator and digit count unchanged (pattern consumed, not retried).
REQ-019 SHALL move to HOLD on the edge that accepts the DIGITS-th valid digit, so word_valid is high the next cycle (latency 1 clock).
REQ-020 SHALL keep word_out constant throughout HOLD.
REQ-021 SHALL, in HOLD with word_ready=1, return to COLLECT on that edge, clear the accumulator and count to 0, and re-assert seg_ready the next cycle.
REQ-022 SHALL ignore seg_valid in HOLD, including the cycle in which word_ready is sampled.
REQ-023 SHALL ignore word_ready in COLLECT.
REQ-024 SHALL let err_flag setting win over err_clear when both occur on the same edge.
REQ-025 SHALL not let err_flag affect data flow.
REQ-026 SHALL compute the digit count in a ceil(log2(DIGITS+1))-bit counter with no wrap; it never exceeds DIGITS.

Reset
REQ-027 SHALL, while reset is high, asynchronously force state=COLLECT, accumulator=0, count=0 and err_flag=0, giving outputs seg_ready=1, word_valid=0, word_out=0, err_flag=0.
REQ-028 SHALL discard any partial or held word when reset is asserted mid-operation, with no word delivered after reset release.

Structure
REQ-029 SHALL place the 16-entry pattern table, the segment-bit index constants (SEG_A..SEG_G) and the FSM state encoding in a shared package, shared with the existing hex-to-segment decoder.
REQ-030 SHALL implement the pattern lookup as one combinational sub-module, seg7_to_hex (outputs: nibble, valid), instantiated once.

Verification
REQ-031 SHALL cover: reset, then patterns 1001111, 0010010, 0000110, 1001100 each with seg_valid=1 for 1 cycle -> word_valid=1 one cycle after the 4th transfer, word_out=0x1234, seg_ready=0.
REQ-032 SHALL cover: HOLD with word_ready low for 5 cycles while seg_valid=1 with 0000000 -> word_out remains 0x1234, no digits accepted; word_ready=1 -> next cycle word_valid=0, seg_ready=1.
REQ-033 SHALL cover: stream 0001000, 1111111, 1100000, 0110001, 1000010 -> err_flag=1 after the 2nd transfer, word_out=0xABCD.
REQ-034 SHALL cover: err_flag=1, err_clear=1 on the same edge as an invalid transfer -> err_flag stays 1; err_clear alone the next cycle -> err_flag=0.
REQ-035 SHALL cover: reset asserted after 2 valid digits, then 4 digits of 0111000 -> word_out=0xFFFF, no earlier nibbles present.
REQ-036 SHALL cover: exhaustive sweep of all 128 seg_in codes -> exactly the 16 codes of REQ-012 accepted as digits, with correct nibbles.
